// File: rtl/fifo_pkg.sv
// Shared FIFO pointer package: pointer/address typedefs and the modulo-wrapped
// pointer increment used by both the read-side and write-side pointer blocks.
package fifo_pkg;

    localparam int unsigned FIFO_ALEN = 8;

    typedef logic [FIFO_ALEN:0]   ptr_t;
    typedef logic [FIFO_ALEN-1:0] addr_t;

    // Advance a pointer by incr, wrapping modulo 2**pbits. Pointers are
    // carried as 32-bit values so one function serves any pointer width.
    function automatic logic [31:0] ptr_next(
        input logic [31:0] ptr,
        input logic [31:0] incr,
        input int unsigned pbits = FIFO_ALEN + 1
    );
        logic [31:0] mask;
        mask = (pbits >= 32) ? '1 : ((32'd1 << pbits) - 32'd1);
        return (ptr + incr) & mask;
    endfunction

endpackage

// File: rtl/rd_ptr_ptr_reg.sv
// ptr_reg: binary pointer register with asynchronous active-low clear,
// enable, and a fixed increment that wraps modulo 2**WIDTH.
module ptr_reg
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_ALEN + 1,
    parameter int unsigned INCR  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    assign w_next = WIDTH'(ptr_next(32'(r_q), 32'(INCR), WIDTH));

    // Pointer state: clear on reset, advance by INCR when enabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= '0;
        end else if (i_en) begin
            // NOTE: non-blocking so every register samples pre-edge values;
            // blocking here would create order-dependent simulation races.
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rd_ptr.sv
// rd_ptr: read-side pointer, empty flag, RAM read gating and underflow flag
// for a synchronous FIFO of 2**ALEN words.
// Build option: define RDPTR_STICKY_UNDERFLOW_EN to make o_runderflow sticky
// until reset; otherwise it is a one-cycle registered pulse per rejected read.
module rd_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned ALEN = FIFO_ALEN,
    parameter int unsigned INCR = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_ren,
    output logic [ALEN-1:0] o_raddr,
    output logic [ALEN:0]   o_rptr,
    input  logic [ALEN:0]   i_wptr,
    output logic            o_rempty,
    output logic            o_runderflow,
    output logic            o_ram_ren
);

    logic [ALEN:0] w_rptr;
    logic          w_rempty;
    logic          w_ram_ren;
    logic          w_reject;
    logic          r_underflow;

    ptr_reg #(
        .WIDTH (ALEN + 1),
        .INCR  (INCR)
    ) u_ptr_reg (
        .clk  (clk),
        .rstn (rstn),
        .i_en (w_ram_ren),
        .o_q  (w_rptr)
    );

    // Full-width compare: equal pointers including the wrap bit means empty.
    assign w_rempty  = (w_rptr == i_wptr);
    // NOTE: rstn gates the enable so no RAM read is issued while the block
    // is held in reset, even though the pointer compare may show non-empty.
    assign w_ram_ren = i_ren & ~w_rempty & rstn;
    assign w_reject  = i_ren & w_rempty;

    // Underflow flag: registered from the rejected-read condition.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_underflow <= 1'b0;
        end else begin
`ifdef RDPTR_STICKY_UNDERFLOW_EN
            if (w_reject) begin
                r_underflow <= 1'b1;
            end
`else
            r_underflow <= w_reject;
`endif
        end
    end

    assign o_rptr       = w_rptr;
    assign o_raddr      = w_rptr[ALEN-1:0];
    assign o_rempty     = w_rempty;
    assign o_ram_ren    = w_ram_ren;
    assign o_runderflow = r_underflow;

endmodule

// File: tb/tb_rd_ptr.sv
// tb_rd_ptr: table-driven and scoreboard checks of rd_ptr (ALEN=8), with a
// second INCR=4 instance checked during the drain sequence.
module tb_rd_ptr;

`ifdef RDPTR_STICKY_UNDERFLOW_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_ren = 1'b0;
    logic [8:0] i_wptr = 9'h000;
    logic [8:0] i_wptr4 = 9'h040;

    logic [7:0] o_raddr;
    logic [8:0] o_rptr;
    logic       o_rempty;
    logic       o_runderflow;
    logic       o_ram_ren;

    logic [7:0] o4_raddr;
    logic [8:0] o4_rptr;
    logic       o4_rempty;
    logic       o4_runderflow;
    logic       o4_ram_ren;

    rd_ptr #(.ALEN(8), .INCR(1)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_ren        (i_ren),
        .o_raddr      (o_raddr),
        .o_rptr       (o_rptr),
        .i_wptr       (i_wptr),
        .o_rempty     (o_rempty),
        .o_runderflow (o_runderflow),
        .o_ram_ren    (o_ram_ren)
    );

    rd_ptr #(.ALEN(8), .INCR(4)) u_dut4 (
        .clk          (clk),
        .rstn         (rstn),
        .i_ren        (i_ren),
        .o_raddr      (o4_raddr),
        .o_rptr       (o4_rptr),
        .i_wptr       (i_wptr4),
        .o_rempty     (o4_rempty),
        .o_runderflow (o4_runderflow),
        .o_ram_ren    (o4_ram_ren)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] rptr;
        logic       rempty;
        logic       ram_ren;
        logic       uf;
        logic       c4;
        logic [8:0] rptr4;
        string      name;
    } exp_t;

    typedef struct {
        logic       ren;
        logic [8:0] wptr;
        logic [8:0] rptr;
        logic       rempty;
        logic       ram_ren;
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_uf = 1'b0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show in it.
    task automatic drive(input logic ren, input logic [8:0] wptr, input logic [8:0] e_rptr,
                         input logic e_empty, input logic e_ren, input string name,
                         input logic c4 = 1'b0, input logic [8:0] e_rptr4 = 9'h000);
        exp_t e;
        @(posedge clk);
        #1;
        i_ren  = ren;
        i_wptr = wptr;
        e.rptr = e_rptr; e.rempty = e_empty; e.ram_ren = e_ren;
        e.uf = m_uf; e.c4 = c4; e.rptr4 = e_rptr4; e.name = name;
        sb.push_back(e);
        if (!rstn)       m_uf = 1'b0;
        else if (STICKY) m_uf = m_uf | (ren & e_empty);
        else             m_uf = ren & e_empty;
    endtask

    // Scoreboard: compare the queued expectation mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] ra;
            e  = sb.pop_front();
            ra = e.rptr;
            check({e.name, "_rptr"},    o_rptr, e.rptr);
            check({e.name, "_raddr"},   9'(o_raddr), 9'(ra[7:0]));
            check({e.name, "_rempty"},  9'(o_rempty), 9'(e.rempty));
            check({e.name, "_ram_ren"}, 9'(o_ram_ren), 9'(e.ram_ren));
            check({e.name, "_uflow"},   9'(o_runderflow), 9'(e.uf));
            if (e.c4) check({e.name, "_rptr_incr4"}, o4_rptr, e.rptr4);
        end
    end

    initial begin
        logic [8:0] r;
        int         k4;

        // Short sequences: underflow pulse, wrap from 0x0FF, simultaneous wptr change.
        vecs.push_back('{1'b1, 9'h0ff, 9'h0ff, 1'b1, 1'b0, "uflow_rej"});
        vecs.push_back('{1'b0, 9'h0ff, 9'h0ff, 1'b1, 1'b0, "uflow_pulse"});
        vecs.push_back('{1'b0, 9'h0ff, 9'h0ff, 1'b1, 1'b0, "uflow_clear"});
        vecs.push_back('{1'b1, 9'h105, 9'h0ff, 1'b0, 1'b1, "wrap0"});
        vecs.push_back('{1'b1, 9'h105, 9'h100, 1'b0, 1'b1, "wrap1"});
        vecs.push_back('{1'b1, 9'h105, 9'h101, 1'b0, 1'b1, "wrap2"});
        vecs.push_back('{1'b1, 9'h105, 9'h102, 1'b0, 1'b1, "wrap3"});
        vecs.push_back('{1'b1, 9'h105, 9'h103, 1'b0, 1'b1, "wrap4"});
        vecs.push_back('{1'b1, 9'h105, 9'h104, 1'b0, 1'b1, "wrap5"});
        vecs.push_back('{1'b0, 9'h105, 9'h105, 1'b1, 1'b0, "wrap_end"});
        vecs.push_back('{1'b0, 9'h110, 9'h105, 1'b0, 1'b0, "sim_idle"});
        vecs.push_back('{1'b1, 9'h105, 9'h105, 1'b1, 1'b0, "sim_rej"});
        vecs.push_back('{1'b0, 9'h105, 9'h105, 1'b1, 1'b0, "sim_pulse"});
        vecs.push_back('{1'b1, 9'h106, 9'h105, 1'b0, 1'b1, "sim_accept"});
        vecs.push_back('{1'b0, 9'h106, 9'h106, 1'b1, 1'b0, "sim_after"});

        // Reset held with a non-empty compare and a pending read.
        for (int i = 0; i < 10; i++) drive(1'b1, 9'h0ff, 9'h000, 1'b0, 1'b0, "reset");
        @(negedge clk);
        #1;
        i_ren = 1'b0;
        rstn  = 1'b1;

        // Drain to 0x0FF; the INCR=4 instance stops at its own wptr 0x040.
        for (int k = 0; k < 255; k++) begin
            k4 = (k * 4 < 'h40) ? k * 4 : 'h40;
            drive(1'b1, 9'h0ff, 9'(k), 1'b0, 1'b1, "drain", 1'b1, 9'(k4));
        end

        foreach (vecs[i])
            drive(vecs[i].ren, vecs[i].wptr, vecs[i].rptr, vecs[i].rempty, vecs[i].ram_ren, vecs[i].name);

        // Long run through 0x1FF -> 0x000 with the wrap bit clearing.
        r = 9'h106;
        while (r != 9'h003) begin
            drive(1'b1, 9'h003, r, 1'b0, 1'b1, "wrap_msb");
            r = r + 9'd1;
        end
        drive(1'b0, 9'h003, 9'h003, 1'b1, 1'b0, "wrap_msb_end");

        // Back-to-back rejects, then one reject followed by 20 idle cycles.
        for (int i = 0; i < 3; i++) drive(1'b1, 9'h003, 9'h003, 1'b1, 1'b0, "b2b_rej");
        drive(1'b0, 9'h003, 9'h003, 1'b1, 1'b0, "b2b_end");
        drive(1'b1, 9'h003, 9'h003, 1'b1, 1'b0, "hold_rej");
        for (int i = 0; i < 20; i++) drive(1'b0, 9'h003, 9'h003, 1'b1, 1'b0, "hold_idle");

        // Reset asserted mid-read: pointer clears immediately.
        drive(1'b1, 9'h010, 9'h003, 1'b0, 1'b1, "pre_rst0");
        drive(1'b1, 9'h010, 9'h004, 1'b0, 1'b1, "pre_rst1");
        @(posedge clk);
        #3;
        rstn = 1'b0;
        m_uf = 1'b0;
        #1;
        check("async_rst_rptr", o_rptr, 9'h000);
        check("async_rst_ram_ren", 9'(o_ram_ren), 9'h000);
        check("async_rst_uflow", 9'(o_runderflow), 9'h000);
        @(negedge clk);
        #1;
        i_ren = 1'b0;
        rstn  = 1'b1;
        drive(1'b0, 9'h010, 9'h000, 1'b0, 1'b0, "post_rst");
        drive(1'b1, 9'h010, 9'h000, 1'b0, 1'b1, "post_rst_rd");
        drive(1'b0, 9'h010, 9'h001, 1'b0, 1'b0, "post_rst_end");

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 9'(sb.size()), 9'h000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
